video_timing_out: RTL and testbench

- Downstream consumer of the 24-bit pixel stream from the pixel data output stage.
- Generates raster timing (hsync, vsync, data-enable) for the HDMI transmitter.
- Pulls one 24-bit pixel per active-region clock and presents registered RGB aligned with sync/DE.
- Flags underflow when the upstream stage cannot supply a pixel in time.

---
 rtl/video_timing_out.sv | 203 ++++++++++++++++++++
 tb/tb_video_timing_out.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_out.sv
// video_timing_out: free-running raster timing generator and output stage
// for an HDMI transmitter. It pulls one 24-bit pixel from the upstream stage
// on every active-region clock. Sync, data-enable and RGB leave on registers,
// one clock after the counter state that produced them. It raises a sticky
// flag when upstream has no pixel ready in time.
//
// Optional build macro VIDEO_TIMING_TEST_PATTERN_EN adds a testMode input.
// When testMode is set, it replaces the pixel stream with eight vertical
// colour bars.
//
// reset_n asserts asynchronously. Its release is expected to be synchronised
// to clock before it reaches this block.
module video_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [23:0] pixelData,
    input  logic        pixelValid,
    output logic        pixelReady,
    output logic        frameStart,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [23:0] rgb,
    output logic        underflow,
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    input  logic        testMode,
`endif
    input  logic        underflowClr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ONE      = HW'(1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ONE      = VW'(1);

    logic [HW-1:0] h_count_reg, h_count_next;
    logic [VW-1:0] v_count_reg, v_count_next;
    logic          line_end;
    logic          frame_first;
    logic          active;
    logic          h_in_sync;
    logic          v_in_sync;
    logic          test_active;
    logic [23:0]   pattern_rgb;
    logic          fetch;
    logic          starve;
    logic [23:0]   rgb_next;

    logic          hsync_reg;
    logic          vsync_reg;
    logic          de_reg;
    logic [23:0]   rgb_reg;
    logic          frame_start_reg;
    logic          underflow_reg;

    // Next raster position: hCount wraps every line, vCount steps on that wrap.
    always_comb begin
        line_end     = (h_count_reg == H_LAST);
        h_count_next = line_end ? '0 : h_count_reg + H_ONE;
        v_count_next = v_count_reg;
        if (line_end) begin
            v_count_next = (v_count_reg == V_LAST) ? '0 : v_count_reg + V_ONE;
        end
    end

    // Free-running raster counters; the raster never stalls for upstream.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_count_reg <= '0;
            v_count_reg <= '0;
        end else begin
            h_count_reg <= h_count_next;
            v_count_reg <= v_count_next;
        end
    end

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [BW-1:0] BAR_ONE  = BW'(1);

    logic          test_mode_reg;
    logic [BW-1:0] bar_px_reg;
    logic [2:0]    bar_idx_reg;

    // testMode is taken at the top-left pixel. That cycle already uses the
    // fresh value, so the whole new frame is consistent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            test_mode_reg <= 1'b0;
        end else if (frame_first) begin
            test_mode_reg <= testMode;
        end
    end

    // Bar position tracks hCount without a divider. The pixel-in-bar and
    // bar-index counters restart on each line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bar_px_reg  <= '0;
            bar_idx_reg <= '0;
        end else if (line_end) begin
            bar_px_reg  <= '0;
            bar_idx_reg <= '0;
        end else if (bar_px_reg == BAR_LAST) begin
            bar_px_reg  <= '0;
            bar_idx_reg <= bar_idx_reg + 3'd1;
        end else begin
            bar_px_reg  <= bar_px_reg + BAR_ONE;
        end
    end

    // Bar colours come straight from the index bits:
    // R = ~idx[1], G = ~idx[2], B = ~idx[0].
    // This gives white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        test_active = frame_first ? testMode : test_mode_reg;
        pattern_rgb = {{8{~bar_idx_reg[1]}}, {8{~bar_idx_reg[2]}}, {8{~bar_idx_reg[0]}}};
    end
`else
    // Without the pattern generator the pixel stream is always live.
    always_comb begin
        test_active = 1'b0;
        pattern_rgb = 24'h000000;
    end
`endif

    // Region decode and the fetch handshake, all from the current counter state.
    always_comb begin
        frame_first = (h_count_reg == '0) && (v_count_reg == '0);
        active      = (h_count_reg < H_ACT_END) && (v_count_reg < V_ACT_END);
        h_in_sync   = (h_count_reg >= H_SYNC_BEG) && (h_count_reg < H_SYNC_END);
        v_in_sync   = (v_count_reg >= V_SYNC_BEG) && (v_count_reg < V_SYNC_END);
        // reset_n gates ready so upstream sees it drop the moment reset asserts.
        pixelReady  = active && !test_active && reset_n;
        fetch       = pixelReady && pixelValid;
        starve      = active && !test_active && !pixelValid;
        rgb_next    = 24'h000000;
        if (active && test_active) begin
            rgb_next = pattern_rgb;
        end else if (fetch) begin
            rgb_next = pixelData;
        end
    end

    // Output pipeline: one clock of latency from counter state to the pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            de_reg          <= 1'b0;
            rgb_reg         <= 24'h000000;
            frame_start_reg <= 1'b0;
        end else begin
            hsync_reg       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            vsync_reg       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
            de_reg          <= active;
            rgb_reg         <= rgb_next;
            frame_start_reg <= frame_first;
        end
    end

    // Sticky underflow flag; a new starve event beats a same-cycle clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underflow_reg <= 1'b0;
        end else if (starve) begin
            underflow_reg <= 1'b1;
        end else if (underflowClr) begin
            underflow_reg <= 1'b0;
        end
    end

    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign de         = de_reg;
    assign rgb        = rgb_reg;
    assign frameStart = frame_start_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_video_timing_out.sv
// Directed bench for video_timing_out using a shrunken raster:
// 24 clocks per line (16 active, FP 2, sync 3, BP 3) and
// 8 lines per frame (4 active, FP 1, sync 2, BP 1), i.e. 192 clocks per frame.
// Each step samples at negedge+1 and compares against values the bench
// predicts from its own cycle index.
module tb_video_timing_out;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
    localparam int HT = 24;   // HA+HF+HS+HB
    localparam int VT = 8;    // VA+VF+VS+VB
    localparam int FT = 192;  // HT*VT

    logic        clock;
    logic        reset_n;
    logic [23:0] pixelData;
    logic        pixelValid;
    logic        pixelReady;
    logic        frameStart;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [23:0] rgb;
    logic        underflow;
    logic        underflowClr;

    int checks = 0;
    int errors = 0;

    // Bench state for the per-cycle prediction
    int          k;
    int          pass_no;
    int          last_fs_k;
    logic        last_xfer;
    logic        exp_de, exp_hs, exp_vs, exp_fs, exp_uf;
    logic [23:0] exp_rgb;
    int          obs_ready_cnt, obs_hs_low, obs_vs_low;

    video_timing_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pixelData   (pixelData),
        .pixelValid  (pixelValid),
        .pixelReady  (pixelReady),
        .frameStart  (frameStart),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .underflow   (underflow),
        .underflowClr(underflowClr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s (k=%0d pass=%0d): observed %0h, expected %0h", tag, k, pass_no, obs, expv);
        end
    endtask

    task automatic model_reset();
        k         = 0;
        last_fs_k = -1;
        last_xfer = 1'b0;
        exp_de    = 1'b0;
        exp_rgb   = 24'h000000;
        exp_hs    = 1'b1;
        exp_vs    = 1'b1;
        exp_fs    = 1'b0;
        exp_uf    = 1'b0;
    endtask

    // One clock cycle. Entered at a falling edge with the counters at
    // state k; leaves at the next falling edge.
    task automatic step();
        int   h, v;
        logic act, xfer, starve;
        #1;
        h   = k % HT;
        v   = (k / HT) % VT;
        act = (h < HA) && (v < VA);

        chk("pixelReady", {31'd0, pixelReady}, {31'd0, act});
        chk("de",         {31'd0, de},         {31'd0, exp_de});
        chk("rgb",        {8'd0, rgb},         {8'd0, exp_rgb});
        chk("hsync",      {31'd0, hsync},      {31'd0, exp_hs});
        chk("vsync",      {31'd0, vsync},      {31'd0, exp_vs});
        chk("frameStart", {31'd0, frameStart}, {31'd0, exp_fs});
        chk("underflow",  {31'd0, underflow},  {31'd0, exp_uf});

        if (pass_no == 1) begin
            if (k == 192) chk("ready_per_frame", obs_ready_cnt, 64);
            if (k == 25)  chk("hsync_low_width", obs_hs_low, 3);
            if (k == 193) chk("vsync_low_clocks", obs_vs_low, 48);
            if (k == 224) chk("uf_after_drop", {31'd0, underflow}, 32'd1);
            if (k < 192 && pixelReady === 1'b1 && pixelValid === 1'b1) obs_ready_cnt++;
            if (k >= 1 && k <= 24 && hsync === 1'b0) obs_hs_low++;
            if (k >= 1 && k <= 192 && vsync === 1'b0) obs_vs_low++;
        end
        if (pass_no == 2 && k == 1) begin
            chk("first_rgb", {8'd0, rgb}, 32'h00A5C3F0);
            chk("first_frameStart", {31'd0, frameStart}, 32'd1);
        end
        if (frameStart === 1'b1) begin
            if (last_fs_k >= 0) chk("frame_period", k - last_fs_k, FT);
            last_fs_k = k;
        end

        // Upstream presents the next pixel only after the previous one was taken.
        if (last_xfer) pixelData = pixelData + 24'd1;

        pixelValid   = 1'b1;
        underflowClr = 1'b0;
        if (pass_no == 1) begin
            if ((k >= 221 && k <= 223) || k == 250 || k == 420) pixelValid = 1'b0;
            if (k == 240 || k == 250 || k == 260) underflowClr = 1'b1;
        end

        xfer    = act && pixelValid;
        starve  = act && !pixelValid;
        exp_de  = act;
        exp_rgb = xfer ? pixelData : 24'h000000;
        exp_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        exp_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        exp_fs  = (h == 0) && (v == 0);
        exp_uf  = starve ? 1'b1 : (underflowClr ? 1'b0 : exp_uf);
        last_xfer = xfer;

        @(negedge clock);
        k++;
    endtask

    initial begin
        reset_n       = 1'b0;
        pixelData     = 24'hA5C3F0;
        pixelValid    = 1'b1;
        underflowClr  = 1'b0;
        pass_no       = 0;
        obs_ready_cnt = 0;
        obs_hs_low    = 0;
        obs_vs_low    = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk("rst_pixelReady", {31'd0, pixelReady}, 32'd0);
        chk("rst_de",         {31'd0, de},         32'd0);
        chk("rst_rgb",        {8'd0, rgb},         32'd0);
        chk("rst_hsync",      {31'd0, hsync},      32'd1);
        chk("rst_vsync",      {31'd0, vsync},      32'd1);
        chk("rst_frameStart", {31'd0, frameStart}, 32'd0);
        chk("rst_underflow",  {31'd0, underflow},  32'd0);
        @(negedge clock);

        // Pass 1: two-plus frames covering line and frame timing, underflow
        // and clear. It stops mid-frame at h=10, v=2 of the third frame.
        pass_no = 1;
        reset_n = 1'b1;
        while (k < 442) step();

        #1;
        chk("pre_rst_pixelReady", {31'd0, pixelReady}, 32'd1);
        chk("pre_rst_de",         {31'd0, de},         32'd1);
        chk("pre_rst_rgb_nonzero", {31'd0, (rgb !== 24'h000000)}, 32'd1);
        chk("pre_rst_underflow",  {31'd0, underflow},  32'd1);

        // Mid-frame reset: outputs must react before any clock edge.
        reset_n = 1'b0;
        #1;
        chk("async_pixelReady", {31'd0, pixelReady}, 32'd0);
        chk("async_de",         {31'd0, de},         32'd0);
        chk("async_rgb",        {8'd0, rgb},         32'd0);
        chk("async_hsync",      {31'd0, hsync},      32'd1);
        chk("async_vsync",      {31'd0, vsync},      32'd1);
        chk("async_frameStart", {31'd0, frameStart}, 32'd0);
        chk("async_underflow",  {31'd0, underflow},  32'd0);
        repeat (2) @(negedge clock);
        #1;
        chk("held_rst_pixelReady", {31'd0, pixelReady}, 32'd0);
        @(negedge clock);

        // Pass 2: restart from 0,0. Check the first fetch and data integrity.
        pass_no    = 2;
        pixelData  = 24'hA5C3F0;
        pixelValid = 1'b1;
        model_reset();
        reset_n    = 1'b1;
        while (k < 60) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
